lut_table_loader: RTL and testbench

//  Upstream feeder for the serial-load LUT. Collects 2**IN_WIDTH table entries over a

---
 rtl/lut_loader_pkg.sv | 15 +
 rtl/lut_piso_shift_reg.sv | 41 ++++
 rtl/lut_table_loader.sv | 133 +++++++++++++
 tb/tb_lut_table_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lut_loader_pkg.sv
// Shared constants and FSM state type for the serial LUT table loader.
package lut_loader_pkg;

   localparam int DEF_IN_WIDTH  = 4;
   localparam int DEF_OUT_WIDTH = 3;
   localparam int TABLE_ENTRIES = 2 ** DEF_IN_WIDTH;
   localparam int TABLE_BITS    = TABLE_ENTRIES * DEF_OUT_WIDTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      SHIFT   = 2'd2
   } state_e;

endpackage

// File: rtl/lut_piso_shift_reg.sv
// Parallel-in serial-out staging register: entries are written slot by slot,
// then the whole table is shifted out MSB-first, mirroring the LUT's own chain.
module lut_piso_shift_reg #(
   parameter int TABLE_BITS = lut_loader_pkg::TABLE_BITS,
   parameter int ENTRY_W    = lut_loader_pkg::DEF_OUT_WIDTH,
   parameter int IDX_W      = lut_loader_pkg::DEF_IN_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_en,
   input  logic [IDX_W-1:0]   load_idx,
   input  logic [ENTRY_W-1:0] load_data,
   input  logic               shift_en,
   output logic               msb_nxt
);

   logic [TABLE_BITS-1:0] data_q;
   logic [TABLE_BITS-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load_en) begin
         data_d[load_idx*ENTRY_W +: ENTRY_W] = load_data;
      end else if (shift_en) begin
         data_d = {data_q[TABLE_BITS-2:0], 1'b0};
      end
   end

   // The bit that will sit at the MSB after this edge; lets the top register
   // lut_d in the same cycle the last entry lands.
   assign msb_nxt = data_d[TABLE_BITS-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/lut_table_loader.sv
// Collects a full LUT table over a valid/ready stream, then shifts it MSB-first
// into the LUT serial chain with lut_cs_n held low for exactly one table length.
module lut_table_loader
   import lut_loader_pkg::*;
#(
   parameter int IN_WIDTH  = DEF_IN_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 entry_valid,
   input  logic [OUT_WIDTH-1:0] entry_data,
   output logic                 entry_ready,
   output logic                 lut_d,
   output logic                 lut_cs_n,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int ENTRIES = 2 ** IN_WIDTH;
   localparam int TBITS   = ENTRIES * OUT_WIDTH;
   localparam int CNT_W   = $clog2(TBITS);
   localparam logic [IN_WIDTH-1:0] LAST_IDX = IN_WIDTH'(ENTRIES - 1);
   localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(TBITS - 1);

   state_e              state_q, state_d;
   logic [IN_WIDTH-1:0] idx_q, idx_d;
   logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
   logic                entry_ready_q, entry_ready_d;
   logic                lut_d_q, lut_d_d;
   logic                lut_cs_n_q, lut_cs_n_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                load_en, shift_en, msb_nxt;

   lut_piso_shift_reg #(
      .TABLE_BITS (TBITS),
      .ENTRY_W    (OUT_WIDTH),
      .IDX_W      (IN_WIDTH)
   ) u_staging (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (load_en),
      .load_idx  (idx_q),
      .load_data (entry_data),
      .shift_en  (shift_en),
      .msb_nxt   (msb_nxt)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      bitcnt_d = bitcnt_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      load_en  = 1'b0;
      shift_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = COLLECT;
               idx_d   = '0;
            end
         end
         COLLECT: begin
            // A restart discards the partial table and beats a coincident handshake.
            if (start) begin
               idx_d = '0;
            end else if (entry_valid && entry_ready_q) begin
               load_en = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d  = SHIFT;
                  idx_d    = '0;
                  bitcnt_d = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         SHIFT: begin
            err_d = start;
            if (bitcnt_q == LAST_BIT) begin
               state_d  = IDLE;
               bitcnt_d = '0;
               done_d   = 1'b1;
            end else begin
               bitcnt_d = bitcnt_q + 1'b1;
               shift_en = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      entry_ready_d = (state_d == COLLECT);
      busy_d        = (state_d != IDLE);
      lut_cs_n_d    = (state_d != SHIFT);
      lut_d_d       = (state_d == SHIFT) && msb_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         bitcnt_q      <= '0;
         entry_ready_q <= 1'b0;
         lut_d_q       <= 1'b0;
         lut_cs_n_q    <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         bitcnt_q      <= bitcnt_d;
         entry_ready_q <= entry_ready_d;
         lut_d_q       <= lut_d_d;
         lut_cs_n_q    <= lut_cs_n_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   assign entry_ready = entry_ready_q;
   assign lut_d       = lut_d_q;
   assign lut_cs_n    = lut_cs_n_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_lut_table_loader.sv
// Bench for lut_table_loader driving a behavioural serial-load LUT (SIPO chain,
// LSB in, shared clk/rst_n); expected tables come from the entries the bench sent.
module tb_lut_table_loader;

   localparam int OW = 3;
   localparam int NE = 16;
   localparam int TB = NE * OW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          entry_valid = 1'b0;
   logic [OW-1:0] entry_data = '0;
   logic          entry_ready, lut_d, lut_cs_n, busy, done, err;

   int errors = 0;
   int checks = 0;
   int cs_cnt = 0, done_cnt = 0, err_cnt = 0, hs_cnt = 0;
   logic [TB-1:0] chain;
   logic [OW-1:0] ref_tab [NE];
   bit            seen;

   always #5 clk = ~clk;

   lut_table_loader #(.IN_WIDTH(4), .OUT_WIDTH(OW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .entry_valid (entry_valid),
      .entry_data  (entry_data),
      .entry_ready (entry_ready),
      .lut_d       (lut_d),
      .lut_cs_n    (lut_cs_n),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   // Downstream LUT: shifts lut_d in at the LSB whenever cs_n is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain <= '0;
      else if (!lut_cs_n) chain <= {chain[TB-2:0], lut_d};
   end

   always @(posedge clk) begin
      if (rst_n) begin
         if (!lut_cs_n) cs_cnt <= cs_cnt + 1;
         if (done) done_cnt <= done_cnt + 1;
         if (err) err_cnt <= err_cnt + 1;
         if (entry_valid && entry_ready) hs_cnt <= hs_cnt + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic [OW-1:0] pat_val(input int pat, input int i);
      case (pat)
         0:       return OW'(i % 8);
         1:       return OW'(7 - (i % 8));
         2:       return 3'b111;
         3:       return 3'b010;
         default: return OW'($urandom);
      endcase
   endfunction

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   // Offers entries at negedges; an entry counts as accepted when ready is
   // high while it is offered. Returns on the negedge after the last acceptance.
   task automatic push(input int n, input int pat, input bit gaps, input bit store);
      int i = 0;
      int guard = 0;
      while (i < n && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (gaps && $urandom_range(0, 1) == 1) begin
            entry_valid = 1'b0;
         end else begin
            entry_valid = 1'b1;
            entry_data  = pat_val(pat, i);
            if (entry_ready) begin
               if (store) ref_tab[i] = entry_data;
               i++;
            end
         end
      end
      chk("push_count", 64'(i), 64'(n));
      @(negedge clk);
      entry_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit start_on_done, output bit got);
      got = 1'b0;
      for (int c = 0; c < budget && !got; c++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            chk("done_cs_n", 64'(lut_cs_n), 64'(1));
            chk("done_lut_d", 64'(lut_d), 64'(0));
            chk("done_busy", 64'(busy), 64'(0));
            if (start_on_done) start = 1'b1;
         end
      end
      chk("done_seen", 64'(got), 64'(1));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_table(input string tag);
      for (int s = 0; s < NE; s++) begin
         chk(tag, 64'(chain[s*OW +: OW]), 64'(ref_tab[s]));
      end
   endtask

   task automatic run_load(input int pat, input bit gaps, input bit start_on_done);
      int b_cs, b_done, b_hs;
      bit got;
      b_cs = cs_cnt; b_done = done_cnt; b_hs = hs_cnt;
      pulse_start();
      chk("collect_ready", 64'(entry_ready), 64'(1));
      chk("collect_busy", 64'(busy), 64'(1));
      push(NE, pat, gaps, 1'b1);
      chk("ready_low_in_shift", 64'(entry_ready), 64'(0));
      chk("cs_n_low_in_shift", 64'(lut_cs_n), 64'(0));
      wait_done(200, start_on_done, got);
      chk("cs_low_cycles", 64'(cs_cnt - b_cs), 64'(TB));
      chk("done_pulses", 64'(done_cnt - b_done), 64'(1));
      chk("accepted", 64'(hs_cnt - b_hs), 64'(NE));
      check_table("lut_sel");
   endtask

   initial begin
      int b_cs, b_done, b_err;
      // Reset state
      repeat (3) step();
      chk("rst_cs_n", 64'(lut_cs_n), 64'(1));
      chk("rst_lut_d", 64'(lut_d), 64'(0));
      chk("rst_ready", 64'(entry_ready), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      rst_n = 1'b1;
      repeat (2) step();
      chk("idle_ready", 64'(entry_ready), 64'(0));

      // Back-to-back i%8, then 7-(i%8) with random gaps
      run_load(0, 1'b0, 1'b0);
      for (int s = 0; s < NE; s++) chk("sel_low_bits", 64'(chain[s*OW +: OW]), 64'(s % 8));
      run_load(1, 1'b1, 1'b0);
      for (int s = 0; s < NE; s++) chk("sel_inverted", 64'(chain[s*OW +: OW]), 64'(7 - (s % 8)));

      // Restart mid-collect, second restart coincides with an offered entry
      pulse_start();
      push(5, 2, 1'b0, 1'b0);
      @(negedge clk); start = 1'b1; entry_valid = 1'b1; entry_data = 3'b111;
      @(negedge clk); start = 1'b0; entry_valid = 1'b0;
      push(NE, 3, 1'b0, 1'b1);
      wait_done(200, 1'b0, seen);
      chk("restart_table", 64'(chain), 64'({NE{3'b010}}));

      // start during SHIFT: err pulse, shift undisturbed
      b_cs = cs_cnt; b_done = done_cnt; b_err = err_cnt;
      pulse_start();
      push(NE, 4, 1'b0, 1'b1);
      repeat (10) step();
      start = 1'b1;
      step();
      chk("err_pulse", 64'(err), 64'(1));
      chk("err_cs_n", 64'(lut_cs_n), 64'(0));
      start = 1'b0;
      step();
      chk("err_cleared", 64'(err), 64'(0));
      wait_done(200, 1'b0, seen);
      chk("err_cs_cycles", 64'(cs_cnt - b_cs), 64'(TB));
      chk("err_done", 64'(done_cnt - b_done), 64'(1));
      chk("err_count", 64'(err_cnt - b_err), 64'(1));
      chk("err_not_collecting", 64'(entry_ready), 64'(0));
      check_table("err_table");

      // Reset at shift cycle 20
      b_done = done_cnt;
      pulse_start();
      push(NE, 1, 1'b0, 1'b1);
      repeat (20) step();
      rst_n = 1'b0;
      #1;
      chk("abort_cs_n", 64'(lut_cs_n), 64'(1));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_lut_d", 64'(lut_d), 64'(0));
      chk("abort_lut_clear", 64'(chain), 64'(0));
      step();
      rst_n = 1'b1;
      repeat (60) step();
      chk("abort_no_done", 64'(done_cnt - b_done), 64'(0));
      chk("abort_lut_zero", 64'(chain), 64'(0));

      // Full load after abort, start taken in the done cycle, random table
      run_load(4, 1'b1, 1'b1);
      chk("start_on_done_ready", 64'(entry_ready), 64'(1));
      chk("start_on_done_busy", 64'(busy), 64'(1));
      run_load(4, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
